div_frec_prog: RTL and testbench

DIV_FREC_PROG -- requirements
Module: div_frec_prog

---
 rtl/div_frec_prog.sv | 111 +++++++++++
 tb/tb_div_frec_prog.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/div_frec_prog.sv
// rtl/div_frec_prog.sv - multi-channel programmable frequency divider
// New divisors wait in a shadow register and are committed at a period boundary or while idle.
module div_frec_prog #(
  parameter int WIDTH       = 12,
  parameter int NCH         = 2,
  parameter int CHW         = 1,
  parameter int DEFAULT_DIV = 4095
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   en,
  input  logic [NCH-1:0]   mode,
  input  logic             div_wr,
  input  logic [CHW-1:0]   div_ch,
  input  logic [WIDTH-1:0] div_in,
  output logic [NCH-1:0]   nclk,
  output logic [NCH-1:0]   tick,
  output logic             div_ack,
  output logic             div_err
);

  localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [CHW:0]     NCH_L   = (CHW + 1)'(NCH);

  logic [WIDTH-1:0] d_q [NCH];
  logic [WIDTH-1:0] d_d [NCH];
  logic [WIDTH-1:0] s_q [NCH];
  logic [WIDTH-1:0] s_d [NCH];
  logic [WIDTH-1:0] c_q [NCH];
  logic [WIDTH-1:0] c_d [NCH];
  logic [NCH-1:0]   p_q, p_d;
  logic [NCH-1:0]   nclk_q, nclk_d;
  logic [NCH-1:0]   tick_q, tick_d;
  logic             div_ack_q, div_ack_d;
  logic             div_err_q, div_err_d;
  logic             ch_valid;

  assign ch_valid = {1'b0, div_ch} < NCH_L;

  always_comb begin
    div_ack_d = div_wr && ch_valid;
    div_err_d = div_wr && !ch_valid;
    p_d       = p_q;
    nclk_d    = nclk_q;
    tick_d    = '0;
    for (int i = 0; i < NCH; i++) begin
      d_d[i] = d_q[i];
      s_d[i] = s_q[i];
      c_d[i] = c_q[i];
      if (en[i]) begin
        if (c_q[i] == d_q[i]) begin
          c_d[i]    = '0;
          tick_d[i] = 1'b1;
          nclk_d[i] = mode[i] | ~nclk_q[i];
          if (p_q[i]) begin
            d_d[i] = s_q[i];
            p_d[i] = 1'b0;
          end
        end else begin
          c_d[i] = c_q[i] + 1'b1;
          if (mode[i]) nclk_d[i] = 1'b0;
        end
      end else begin
        if (mode[i]) nclk_d[i] = 1'b0;
        // An idle channel has no period to protect, so commit the shadow now.
        if (p_q[i]) begin
          d_d[i] = s_q[i];
          p_d[i] = 1'b0;
          c_d[i] = '0;
        end
      end
      // The write lands after the commit above, so a coincident write stays pending.
      if (div_wr && ch_valid && (div_ch == CHW'(i))) begin
        s_d[i] = div_in;
        p_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        d_q[i] <= RST_DIV;
        s_q[i] <= RST_DIV;
        c_q[i] <= '0;
      end
      p_q       <= '0;
      nclk_q    <= '0;
      tick_q    <= '0;
      div_ack_q <= 1'b0;
      div_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        d_q[i] <= d_d[i];
        s_q[i] <= s_d[i];
        c_q[i] <= c_d[i];
      end
      p_q       <= p_d;
      nclk_q    <= nclk_d;
      tick_q    <= tick_d;
      div_ack_q <= div_ack_d;
      div_err_q <= div_err_d;
    end
  end

  assign nclk    = nclk_q;
  assign tick    = tick_q;
  assign div_ack = div_ack_q;
  assign div_err = div_err_q;

endmodule

// File: tb/tb_div_frec_prog.sv
// tb/tb_div_frec_prog.sv - self-checking bench for div_frec_prog
// Directed scenarios plus random traffic, all compared against a cycle model.
module tb_div_frec_prog;

  localparam int WIDTH = 12;
  localparam int NCH   = 2;
  localparam int CHW   = 2;
  localparam int DDIV  = 4095;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   en;
  logic [NCH-1:0]   mode;
  logic             div_wr;
  logic [CHW-1:0]   div_ch;
  logic [WIDTH-1:0] div_in;
  logic [NCH-1:0]   nclk;
  logic [NCH-1:0]   tick;
  logic             div_ack;
  logic             div_err;

  int n_checks = 0;
  int n_errors = 0;

  int m_d [NCH];
  int m_s [NCH];
  int m_p [NCH];
  int m_c [NCH];
  int m_nclk [NCH];
  int m_tick [NCH];
  int m_ack, m_err;

  div_frec_prog #(
    .WIDTH(WIDTH), .NCH(NCH), .CHW(CHW), .DEFAULT_DIV(DDIV)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .div_wr(div_wr), .div_ch(div_ch), .div_in(div_in),
    .nclk(nclk), .tick(tick), .div_ack(div_ack), .div_err(div_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_d[i] = DDIV; m_s[i] = DDIV; m_p[i] = 0; m_c[i] = 0;
        m_nclk[i] = 0; m_tick[i] = 0;
      end
      m_ack = 0;
      m_err = 0;
    end else begin
      m_ack = (div_wr && int'(div_ch) < NCH) ? 1 : 0;
      m_err = (div_wr && int'(div_ch) >= NCH) ? 1 : 0;
      for (int i = 0; i < NCH; i++) begin
        m_tick[i] = 0;
        if (en[i] && m_c[i] == m_d[i]) begin
          m_c[i] = 0;
          m_tick[i] = 1;
          m_nclk[i] = mode[i] ? 1 : 1 - m_nclk[i];
          if (m_p[i] == 1) begin m_d[i] = m_s[i]; m_p[i] = 0; end
        end else if (en[i]) begin
          m_c[i] = m_c[i] + 1;
          if (mode[i]) m_nclk[i] = 0;
        end else begin
          if (mode[i]) m_nclk[i] = 0;
          if (m_p[i] == 1) begin m_d[i] = m_s[i]; m_p[i] = 0; m_c[i] = 0; end
        end
        if (m_c[i] > m_d[i]) check_eq("model_c_bound", m_c[i], m_d[i]);
        if (div_wr && int'(div_ch) == i) begin m_s[i] = int'(div_in); m_p[i] = 1; end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_eq("nclk", int'(nclk), m_nclk[0] + 2 * m_nclk[1]);
    check_eq("tick", int'(tick), m_tick[0] + 2 * m_tick[1]);
    check_eq("div_ack", int'(div_ack), m_ack);
    check_eq("div_err", int'(div_err), m_err);
  endtask

  task automatic wait_toggle(output int n);
    logic start;
    start = nclk[0];
    n = 0;
    while (nclk[0] == start && n < 6000) begin
      step();
      n++;
    end
    if (n >= 6000) n = -1;
  endtask

  initial begin
    int n, highs;
    logic prev;
    rst = 1'b1; en = '0; mode = '0; div_wr = 1'b0; div_ch = '0; div_in = '0;
    step();
    step();
    check_eq("rst_nclk", int'(nclk), 0);
    check_eq("rst_tick", int'(tick), 0);
    rst = 1'b0;

    en = 2'b01; mode = 2'b00;
    wait_toggle(n);
    check_eq("first_rise", n, 4096);
    check_eq("ch1_static", int'(nclk[1]), 0);
    wait_toggle(n);
    check_eq("first_fall", n, 4096);

    repeat (100) step();
    div_wr = 1'b1; div_ch = 2'd0; div_in = 12'd3;
    step();
    div_wr = 1'b0;
    check_eq("wr_ack", int'(div_ack), 1);
    wait_toggle(n);
    check_eq("old_period_kept", n, 4096 - 101);
    wait_toggle(n);
    check_eq("new_half_period_a", n, 4);
    wait_toggle(n);
    check_eq("new_half_period_b", n, 4);

    en = 2'b00;
    div_wr = 1'b1; div_ch = 2'd0; div_in = 12'd0;
    step();
    div_wr = 1'b0;
    step();
    en = 2'b01;
    for (int k = 0; k < 6; k++) begin
      prev = nclk[0];
      step();
      check_eq("d0_toggle", int'(nclk[0]), int'(!prev));
      check_eq("d0_tick", int'(tick[0]), 1);
    end

    en = 2'b00; mode = 2'b01;
    div_wr = 1'b1; div_ch = 2'd0; div_in = 12'd4;
    step();
    div_wr = 1'b0;
    step();
    en = 2'b01;
    highs = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      highs += int'(nclk[0]);
    end
    check_eq("pulse_count", highs, 4);
    div_wr = 1'b1; div_ch = 2'd3; div_in = 12'd1;
    step();
    div_wr = 1'b0;
    check_eq("bad_ch_err", int'(div_err), 1);
    check_eq("bad_ch_ack", int'(div_ack), 0);
    highs = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      highs += int'(nclk[0]);
    end
    check_eq("pulse_after_bad_wr", highs, 2);

    mode = 2'b00;
    div_wr = 1'b1; div_ch = 2'd0; div_in = 12'd2;
    step();
    div_wr = 1'b0;
    n = 0;
    while (m_c[0] != m_d[0] && n < 20) begin step(); n++; end
    check_eq("found_tc", int'(n < 20), 1);
    div_wr = 1'b1; div_ch = 2'd0; div_in = 12'd6;
    step();
    div_wr = 1'b0;
    wait_toggle(n);
    check_eq("coincident_old_applied", n, 3);
    step();
    rst = 1'b1;
    step();
    check_eq("midrst_nclk", int'(nclk), 0);
    check_eq("midrst_tick", int'(tick), 0);
    check_eq("midrst_ack", int'(div_ack), 0);
    rst = 1'b0;
    wait_toggle(n);
    check_eq("post_rst_half_a", n, 4096);
    wait_toggle(n);
    check_eq("post_rst_half_b", n, 4096);

    for (int k = 0; k < 4000; k++) begin
      rst    = ($urandom_range(0, 149) == 0);
      en     = NCH'($urandom_range(0, 3));
      mode   = ($urandom_range(0, 15) == 0) ? NCH'($urandom_range(0, 3)) : mode;
      div_wr = ($urandom_range(0, 3) == 0);
      div_ch = CHW'($urandom_range(0, 3));
      div_in = WIDTH'($urandom_range(0, 9));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
